// File: rtl/dmem_arb_pkg.sv
// Shared types, default widths and helpers for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned ADDR_W_DFLT = 16;
  localparam int unsigned DATA_W_DFLT = 16;
  localparam int unsigned LEN_W_DFLT  = 4;
  localparam int unsigned CNT_W       = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  // Increment that holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Counts consecutive cycles a pending DMA beat lost to the CPU; saturates at LIMIT.
module dmem_arb_starve_ctr #(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam int unsigned CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  assign at_limit = (cnt == CW'(LIMIT));

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_limit) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: CPU MEM stage has priority, DMA bursts
// are guaranteed progress by a starvation counter.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DFLT,
  parameter int unsigned DATA_W       = DATA_W_DFLT,
  parameter int unsigned LEN_W        = LEN_W_DFLT,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [LEN_W-1:0]  dma_len,
  input  logic              dma_abort,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  cpu_stall_cycles,
  output logic [CNT_W-1:0]  dma_words
);

  arb_state_t        state;
  logic [ADDR_W-1:0] base;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  beat;
  logic              lat_we;

  logic              at_limit;
  logic              beat_go;
  logic              last_beat;
  logic              starve_inc;
  logic              starve_clr;
  logic [ADDR_W-1:0] burst_addr;

  assign burst_addr = base + ADDR_W'(beat);

  dmem_arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .reset    (reset),
    .inc      (starve_inc),
    .clr      (starve_clr),
    .at_limit (at_limit)
  );

  // Arbitration and memory routing; abort and reset both suppress the beat.
  always_comb begin
    beat_go    = reset && (state == BURST) && !dma_abort && (!cpu_req || at_limit);
    last_beat  = (beat == len);
    starve_inc = reset && (state == BURST) && !dma_abort && cpu_req && !at_limit;
    starve_clr = beat_go || (state == IDLE);

    mem_addr   = cpu_addr;
    mem_wdata  = cpu_wdata;
    mem_we     = reset && cpu_req && cpu_we;
    if (beat_go) begin
      mem_addr  = burst_addr;
      mem_wdata = dma_wdata;
      mem_we    = lat_we;
    end

    cpu_rdata = mem_rdata;
    dma_rdata = mem_rdata;
    dma_gnt   = beat_go;
    dma_done  = beat_go && last_beat;
    cpu_stall = beat_go && cpu_req;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state            <= IDLE;
      base             <= '0;
      len              <= '0;
      beat             <= '0;
      lat_we           <= 1'b0;
      cpu_stall_cycles <= '0;
      dma_words        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dma_req) begin
            base   <= dma_addr;
            len    <= dma_len;
            lat_we <= dma_we;
            beat   <= '0;
            state  <= BURST;
          end
        end
        BURST: begin
          if (dma_abort) begin
            state <= IDLE;
          end else if (beat_go) begin
            if (last_beat) begin
              state <= IDLE;
            end else begin
              beat <= beat + LEN_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (cpu_stall) cpu_stall_cycles <= sat_inc(cpu_stall_cycles);
      if (dma_gnt)   dma_words        <= sat_inc(dma_words);
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed table, corner sequences and
// randomized traffic checked against a queue-based burst model.
module tb_dmem_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dma_req, dma_we, dma_abort;
  logic [15:0] dma_addr, dma_wdata, dma_rdata;
  logic [3:0]  dma_len;
  logic        dma_gnt, dma_done;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;
  logic [15:0] cpu_stall_cycles, dma_words;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_len(dma_len),
    .dma_abort(dma_abort), .dma_wdata(dma_wdata), .dma_gnt(dma_gnt),
    .dma_rdata(dma_rdata), .dma_done(dma_done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .cpu_stall_cycles(cpu_stall_cycles), .dma_words(dma_words)
  );

  // Memory attached to the DUT
  logic [15:0] dut_mem [65536];
  assign mem_rdata = dut_mem[mem_addr];
  always @(posedge clk) if (mem_we) dut_mem[mem_addr] <= mem_wdata;

  // Reference model: a burst is a queue of pending beat addresses
  logic [15:0] ref_mem [65536];
  bit          m_busy;
  bit          m_we;
  int          q[$];
  int          m_starve, m_stall_cnt, m_words;
  logic        e_gnt, e_we, e_stall, e_done;
  logic [15:0] e_addr, e_wdata, e_rd;

  int n_checks = 0;
  int n_fail   = 0;

  logic        obs_gnt, obs_done, obs_stall, obs_we;
  logic [15:0] obs_addr, obs_crd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_check();
    e_gnt   = reset && m_busy && !dma_abort && (!cpu_req || m_starve == LIMIT);
    e_addr  = e_gnt ? 16'(q[0]) : cpu_addr;
    e_wdata = e_gnt ? dma_wdata : cpu_wdata;
    e_we    = reset && (e_gnt ? m_we : (cpu_req && cpu_we));
    e_stall = e_gnt && cpu_req;
    e_done  = e_gnt && (q.size() == 1);
    e_rd    = ref_mem[e_addr];
    chk("mem_we", 32'(mem_we), 32'(e_we));
    chk("mem_addr", 32'(mem_addr), 32'(e_addr));
    if (e_we) chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
    chk("dma_gnt", 32'(dma_gnt), 32'(e_gnt));
    chk("dma_done", 32'(dma_done), 32'(e_done));
    chk("cpu_stall", 32'(cpu_stall), 32'(e_stall));
    chk("cpu_rdata", 32'(cpu_rdata), 32'(e_rd));
    if (e_gnt) chk("dma_rdata", 32'(dma_rdata), 32'(e_rd));
    chk("cpu_stall_cycles", 32'(cpu_stall_cycles), 32'(m_stall_cnt));
    chk("dma_words", 32'(dma_words), 32'(m_words));
  endtask

  task automatic model_update();
    if (!reset) begin
      m_busy = 0; q.delete(); m_starve = 0; m_stall_cnt = 0; m_words = 0;
    end else begin
      if (e_we) ref_mem[e_addr] = e_wdata;
      if (e_stall && m_stall_cnt < 65535) m_stall_cnt++;
      if (e_gnt && m_words < 65535) m_words++;
      if (!m_busy) begin
        if (dma_req) begin
          m_busy = 1; m_we = dma_we; m_starve = 0;
          for (int i = 0; i <= int'(dma_len); i++) q.push_back((int'(dma_addr) + i) % 65536);
        end
      end else if (dma_abort) begin
        m_busy = 0; q.delete();
      end else if (e_gnt) begin
        void'(q.pop_front());
        m_starve = 0;
        if (q.size() == 0) m_busy = 0;
      end else if (cpu_req) begin
        m_starve = (m_starve == LIMIT) ? LIMIT : m_starve + 1;
      end
    end
  endtask

  // Inputs are driven at the falling edge; outputs checked 2ns later.
  task automatic step();
    #2;
    model_check();
    obs_gnt = dma_gnt; obs_done = dma_done; obs_stall = cpu_stall;
    obs_we = mem_we; obs_addr = mem_addr; obs_crd = cpu_rdata;
    model_update();
    @(negedge clk);
  endtask

  task automatic idle_in();
    cpu_req = 0; cpu_we = 0; cpu_addr = 16'h0; cpu_wdata = 16'h0;
    dma_req = 0; dma_we = 0; dma_addr = 16'h0; dma_len = 4'h0; dma_abort = 0; dma_wdata = 16'h0;
  endtask

  task automatic start_burst(input logic we, input logic [15:0] a, input logic [3:0] l);
    dma_req = 1; dma_we = we; dma_addr = a; dma_len = l;
    step();
    dma_req = 0;
  endtask

  typedef struct {
    logic rst, creq, cwe; logic [15:0] caddr, cwdata;
    logic dreq, dwe; logic [15:0] daddr; logic [3:0] dlen; logic [15:0] dwdata;
    logic e_we; logic [15:0] e_addr; logic e_stall, e_gnt, e_done, chk_rd; logic [15:0] e_rd;
  } vec_t;

  function automatic vec_t mk(input logic rst, creq, cwe, input logic [15:0] caddr, cwdata,
                              input logic dreq, dwe, input logic [15:0] daddr, input logic [3:0] dlen,
                              input logic [15:0] dwdata, input logic xwe, input logic [15:0] xaddr,
                              input logic xstall, xgnt, xdone, crd, input logic [15:0] xrd);
    vec_t v;
    v.rst = rst; v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwdata = cwdata;
    v.dreq = dreq; v.dwe = dwe; v.daddr = daddr; v.dlen = dlen; v.dwdata = dwdata;
    v.e_we = xwe; v.e_addr = xaddr; v.e_stall = xstall; v.e_gnt = xgnt; v.e_done = xdone;
    v.chk_rd = crd; v.e_rd = xrd;
    return v;
  endfunction

  initial begin
    vec_t        tbl[$];
    int          gmask, smask, dmask, cnt_g, cnt_d;
    logic [15:0] wrap_seen[$];
    logic [15:0] wrap_exp[4];

    for (int i = 0; i < 65536; i++) begin
      dut_mem[i] = 16'(i) ^ 16'h5A5A;
      ref_mem[i] = 16'(i) ^ 16'h5A5A;
    end
    m_busy = 0; m_starve = 0; m_stall_cnt = 0; m_words = 0;
    idle_in();
    reset = 0;
    @(negedge clk); @(negedge clk);

    // Reset, CPU store/load, DMA write burst of 4 beats
    tbl.push_back(mk(0,1,1,16'h0010,16'hBEEF, 0,0,16'h0,4'h0,16'h0, 0,16'h0010,0,0,0,0,16'h0));
    tbl.push_back(mk(1,1,1,16'h0010,16'hBEEF, 0,0,16'h0,4'h0,16'h0, 1,16'h0010,0,0,0,0,16'h0));
    tbl.push_back(mk(1,1,0,16'h0010,16'h0,    0,0,16'h0,4'h0,16'h0, 0,16'h0010,0,0,0,1,16'hBEEF));
    tbl.push_back(mk(1,0,0,16'h0,16'h0,       1,1,16'h0100,4'h3,16'h0, 0,16'h0,0,0,0,0,16'h0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1,0,0,16'h0,16'h0, 0,0,16'h0,4'h0,16'hD000 + 16'(i),
                       1,16'h0100 + 16'(i),0,1,(i == 3),0,16'h0));
    tbl.push_back(mk(1,0,0,16'h0,16'h0,       0,0,16'h0,4'h0,16'h0, 0,16'h0,0,0,0,0,16'h0));
    tbl.push_back(mk(1,1,0,16'h0102,16'h0,    0,0,16'h0,4'h0,16'h0, 0,16'h0102,0,0,0,1,16'hD002));

    foreach (tbl[i]) begin
      reset = tbl[i].rst; cpu_req = tbl[i].creq; cpu_we = tbl[i].cwe;
      cpu_addr = tbl[i].caddr; cpu_wdata = tbl[i].cwdata;
      dma_req = tbl[i].dreq; dma_we = tbl[i].dwe; dma_addr = tbl[i].daddr;
      dma_len = tbl[i].dlen; dma_wdata = tbl[i].dwdata; dma_abort = 0;
      step();
      chk($sformatf("vec%0d.mem_we", i), 32'(obs_we), 32'(tbl[i].e_we));
      chk($sformatf("vec%0d.mem_addr", i), 32'(obs_addr), 32'(tbl[i].e_addr));
      chk($sformatf("vec%0d.stall", i), 32'(obs_stall), 32'(tbl[i].e_stall));
      chk($sformatf("vec%0d.gnt", i), 32'(obs_gnt), 32'(tbl[i].e_gnt));
      chk($sformatf("vec%0d.done", i), 32'(obs_done), 32'(tbl[i].e_done));
      if (tbl[i].chk_rd) chk($sformatf("vec%0d.rdata", i), 32'(obs_crd), 32'(tbl[i].e_rd));
    end
    #1 chk("table.dma_words", 32'(dma_words), 32'd4);

    // Starvation: CPU requests every cycle, 2-beat DMA read
    idle_in(); reset = 0; step(); reset = 1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0020;
    start_burst(1'b0, 16'h0200, 4'h1);
    gmask = 0; smask = 0; dmask = 0;
    for (int i = 0; i < 11; i++) begin
      step();
      if (obs_gnt)   gmask |= (1 << i);
      if (obs_stall) smask |= (1 << i);
      if (obs_done)  dmask |= (1 << i);
    end
    chk("starve.gnt_pattern", 32'(gmask), 32'h210);
    chk("starve.stall_pattern", 32'(smask), 32'h210);
    chk("starve.done_pattern", 32'(dmask), 32'h200);
    #1 chk("starve.stall_cycles", 32'(cpu_stall_cycles), 32'd2);
    @(negedge clk);

    // Address wrap across 0xFFFF
    idle_in(); reset = 0; step(); reset = 1;
    start_burst(1'b0, 16'hFFFE, 4'h3);
    for (int i = 0; i < 6; i++) begin
      step();
      if (obs_gnt) wrap_seen.push_back(obs_addr);
    end
    wrap_exp[0] = 16'hFFFE; wrap_exp[1] = 16'hFFFF; wrap_exp[2] = 16'h0000; wrap_exp[3] = 16'h0001;
    chk("wrap.beats", 32'(wrap_seen.size()), 32'd4);
    for (int i = 0; i < 4 && i < wrap_seen.size(); i++)
      chk($sformatf("wrap.addr%0d", i), 32'(wrap_seen[i]), 32'(wrap_exp[i]));

    // Abort after 2 of 8 beats
    idle_in(); reset = 0; step(); reset = 1;
    start_burst(1'b1, 16'h0300, 4'h7);
    step(); step();
    dma_abort = 1; step(); dma_abort = 0;
    cnt_g = 0; cnt_d = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      cnt_g += int'(obs_gnt); cnt_d += int'(obs_done);
    end
    chk("abort.late_gnts", 32'(cnt_g), 32'd0);
    chk("abort.dones", 32'(cnt_d), 32'd0);
    #1 chk("abort.dma_words", 32'(dma_words), 32'd2);
    @(negedge clk);

    // Reset mid-burst
    start_burst(1'b1, 16'h0400, 4'h7);
    step(); step();
    reset = 0; step(); reset = 1;
    cnt_g = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      cnt_g += int'(obs_gnt);
    end
    chk("rstmid.gnts", 32'(cnt_g), 32'd0);
    #1 chk("rstmid.dma_words", 32'(dma_words), 32'd0);
    chk("rstmid.stall_cycles", 32'(cpu_stall_cycles), 32'd0);
    @(negedge clk);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 199) != 0);
      cpu_req   = ($urandom_range(0, 99) < 60);
      cpu_we    = 1'($urandom_range(0, 1));
      cpu_addr  = 16'($urandom_range(0, 63));
      cpu_wdata = 16'($urandom);
      dma_req   = ($urandom_range(0, 99) < 30);
      dma_we    = 1'($urandom_range(0, 1));
      dma_addr  = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(0, 63))
                                              : 16'hFFF0 + 16'($urandom_range(0, 15));
      dma_len   = 4'($urandom_range(0, 15));
      dma_abort = ($urandom_range(0, 99) < 3);
      dma_wdata = 16'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
